dport_arb: RTL and testbench

- Two-requester round-robin arbiter that shares one data-port memory target (TCM data port or dport AXI bridge) between port 0 (CPU dport) and port 1 (DMA/debug master).
- Forwards one request per cycle using the existing mem request/accept handshake and fixed response-tag semantics.
- Tracks owners of outstanding requests in an in-order FIFO and routes each response (ack/error/data/tag) back to the requester that issued it.

---
 rtl/dport_arb.sv | 154 +++++++++++++++
 tb/tb_dport_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dport_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dport_arb                                                      |
// | Function : Two-port round-robin arbiter for a shared data-port target.    |
// |            Zero-latency request mux plus in-order owner FIFO that routes  |
// |            each downstream response back to the port that issued it.     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dport_arb #(
   parameter int OUTSTANDING_DEPTH = 4,
   parameter int OUTSTANDING_W     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // port 0 (CPU dport)
   input  logic [31:0] mem0_addr_i,
   input  logic [31:0] mem0_data_wr_i,
   input  logic        mem0_rd_i,
   input  logic [3:0]  mem0_wr_i,
   input  logic        mem0_cacheable_i,
   input  logic [10:0] mem0_req_tag_i,
   output logic        mem0_accept_o,
   output logic        mem0_ack_o,
   output logic        mem0_error_o,
   output logic [31:0] mem0_data_rd_o,
   output logic [10:0] mem0_resp_tag_o,
   // port 1 (DMA / debug master)
   input  logic [31:0] mem1_addr_i,
   input  logic [31:0] mem1_data_wr_i,
   input  logic        mem1_rd_i,
   input  logic [3:0]  mem1_wr_i,
   input  logic        mem1_cacheable_i,
   input  logic [10:0] mem1_req_tag_i,
   output logic        mem1_accept_o,
   output logic        mem1_ack_o,
   output logic        mem1_error_o,
   output logic [31:0] mem1_data_rd_o,
   output logic [10:0] mem1_resp_tag_o,
   // shared downstream target
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_wr_o,
   output logic        mem_rd_o,
   output logic [3:0]  mem_wr_o,
   output logic        mem_cacheable_o,
   output logic [10:0] mem_req_tag_o,
   input  logic        mem_accept_i,
   input  logic        mem_ack_i,
   input  logic        mem_error_i,
   input  logic [31:0] mem_data_rd_i,
   input  logic [10:0] mem_resp_tag_i
);

   localparam logic [OUTSTANDING_W:0]   c_FULL_COUNT = (OUTSTANDING_W+1)'(OUTSTANDING_DEPTH);
   localparam logic [OUTSTANDING_W:0]   c_CNT_ONE    = (OUTSTANDING_W+1)'(1);
   localparam logic [OUTSTANDING_W-1:0] c_PTR_ONE    = OUTSTANDING_W'(1);

   logic                         r_last;        // port granted by the most recent transfer
   logic                         r_lock;        // a granted request is waiting for accept
   logic                         r_lock_owner;
   logic [OUTSTANDING_DEPTH-1:0] r_owner_fifo;  // owner bit of each outstanding request
   logic [OUTSTANDING_W-1:0]     r_rd_ptr;
   logic [OUTSTANDING_W-1:0]     r_wr_ptr;
   logic [OUTSTANDING_W:0]       r_count;

   logic w_req0, w_req1, w_grant, w_grant_req;
   logic w_full, w_empty, w_gate, w_push, w_pop, w_head;

   assign w_req0  = mem0_rd_i | (|mem0_wr_i);
   assign w_req1  = mem1_rd_i | (|mem1_wr_i);
   assign w_full  = (r_count == c_FULL_COUNT);
   assign w_empty = (r_count == '0);

   // Grant: a stalled request keeps its grant, otherwise alternate on contention
   always_comb begin
      w_grant = 1'b0;
      if (r_lock)
         w_grant = r_lock_owner;
      else if (w_req0 && w_req1)
         w_grant = ~r_last;
      else
         w_grant = w_req1;
   end

   assign w_grant_req = w_grant ? w_req1 : w_req0;

   // Strobes are suppressed while in reset, when the FIFO is full or when idle;
   // the address/data/tag mux still follows the grant so it stays stable.
   assign w_gate = rst_i | w_full | ~(w_req0 | w_req1);

   assign mem_addr_o      = w_grant ? mem1_addr_i      : mem0_addr_i;
   assign mem_data_wr_o   = w_grant ? mem1_data_wr_i   : mem0_data_wr_i;
   assign mem_cacheable_o = w_grant ? mem1_cacheable_i : mem0_cacheable_i;
   assign mem_req_tag_o   = w_grant ? mem1_req_tag_i   : mem0_req_tag_i;
   assign mem_rd_o        = ~w_gate & (w_grant ? mem1_rd_i : mem0_rd_i);
   assign mem_wr_o        = w_gate ? 4'b0000 : (w_grant ? mem1_wr_i : mem0_wr_i);

   assign w_push        = (mem_rd_o | (|mem_wr_o)) & mem_accept_i;
   assign mem0_accept_o = w_push & ~w_grant;
   assign mem1_accept_o = w_push &  w_grant;

   // Responses are in order: the FIFO head names the port that owns this ack
   assign w_pop  = mem_ack_i & ~w_empty;
   assign w_head = r_owner_fifo[r_rd_ptr];

   assign mem0_ack_o      = w_pop & ~w_head;
   assign mem1_ack_o      = w_pop &  w_head;
   assign mem0_error_o    = w_pop & ~w_head & mem_error_i;
   assign mem1_error_o    = w_pop &  w_head & mem_error_i;
   assign mem0_data_rd_o  = mem_data_rd_i;
   assign mem1_data_rd_o  = mem_data_rd_i;
   assign mem0_resp_tag_o = mem_resp_tag_i;
   assign mem1_resp_tag_o = mem_resp_tag_i;

   // Arbitration state: remember the winner, lock the grant across a stall
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last       <= 1'b1;
         r_lock       <= 1'b0;
         r_lock_owner <= 1'b0;
      end else if (w_push) begin
         r_last <= w_grant;
         r_lock <= 1'b0;
      end else if (w_grant_req) begin
         r_lock       <= 1'b1;
         r_lock_owner <= w_grant;
      end else begin
         r_lock <= 1'b0;
      end
   end

   // Owner FIFO: push on transfer, pop on routed ack; pointers wrap naturally
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_owner_fifo <= '0;
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_count      <= '0;
      end else begin
         if (w_push) begin
            r_owner_fifo[r_wr_ptr] <= w_grant;
            r_wr_ptr               <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dport_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dport_arb                                                   |
// | Function : Self-checking bench for dport_arb: directed scenarios followed |
// |            by random traffic against a queue-based reference model.      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dport_arb;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] addr0, wdata0, addr1, wdata1, rdata_dn;
   logic        rd0, rd1, cach0, cach1, acc_dn, ack_dn, err_dn;
   logic [3:0]  wr0, wr1;
   logic [10:0] tag0, tag1, rtag_dn;

   logic        acc0_o, ack0_o, err0_o, acc1_o, ack1_o, err1_o;
   logic [31:0] rdata0_o, rdata1_o, dn_addr, dn_wdata;
   logic [10:0] rtag0_o, rtag1_o, dn_tag;
   logic        dn_rd, dn_cach;
   logic [3:0]  dn_wr;

   dport_arb #(.OUTSTANDING_DEPTH(DEPTH), .OUTSTANDING_W(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .mem0_addr_i(addr0), .mem0_data_wr_i(wdata0), .mem0_rd_i(rd0), .mem0_wr_i(wr0),
      .mem0_cacheable_i(cach0), .mem0_req_tag_i(tag0), .mem0_accept_o(acc0_o),
      .mem0_ack_o(ack0_o), .mem0_error_o(err0_o), .mem0_data_rd_o(rdata0_o),
      .mem0_resp_tag_o(rtag0_o),
      .mem1_addr_i(addr1), .mem1_data_wr_i(wdata1), .mem1_rd_i(rd1), .mem1_wr_i(wr1),
      .mem1_cacheable_i(cach1), .mem1_req_tag_i(tag1), .mem1_accept_o(acc1_o),
      .mem1_ack_o(ack1_o), .mem1_error_o(err1_o), .mem1_data_rd_o(rdata1_o),
      .mem1_resp_tag_o(rtag1_o),
      .mem_addr_o(dn_addr), .mem_data_wr_o(dn_wdata), .mem_rd_o(dn_rd), .mem_wr_o(dn_wr),
      .mem_cacheable_o(dn_cach), .mem_req_tag_o(dn_tag), .mem_accept_i(acc_dn),
      .mem_ack_i(ack_dn), .mem_error_i(err_dn), .mem_data_rd_i(rdata_dn),
      .mem_resp_tag_i(rtag_dn)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: owner queue, last winner, pending-grant lock
   bit          m_q[$];
   logic [10:0] dn_q[$];
   bit          m_last, m_lock, m_lock_owner;
   bit          e_g, e_acc0, e_acc1;

   // values seen on the DUT in the last checked cycle
   logic        s_acc0, s_acc1, s_ack0, s_ack1, s_err0, s_err1, s_rd;
   logic [31:0] s_data0, s_addr;
   logic [10:0] s_tag0, s_tag1;

   bit pend0, pend1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      dn_q.delete();
      m_last       = 1'b1;
      m_lock       = 1'b0;
      m_lock_owner = 1'b0;
   endtask

   task automatic idle_inputs();
      rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
      addr0 = 0; wdata0 = 0; cach0 = 0; tag0 = 0;
      addr1 = 0; wdata1 = 0; cach1 = 0; tag1 = 0;
      acc_dn = 0; ack_dn = 0; err_dn = 0; rdata_dn = 0; rtag_dn = 0;
   endtask

   // one clock: predict and compare at negedge, advance model at posedge
   task automatic cycle();
      bit          req0, req1, full, fwd, push, pop, own, e_rd;
      logic [3:0]  e_wr;
      @(negedge clk);
      req0 = rd0 || (wr0 != 4'h0);
      req1 = rd1 || (wr1 != 4'h0);
      if (m_lock)             e_g = m_lock_owner;
      else if (req0 && req1)  e_g = !m_last;
      else                    e_g = req1;
      full   = (m_q.size() == DEPTH);
      fwd    = !rst && (req0 || req1) && !full;
      e_rd   = fwd && (e_g ? rd1 : rd0);
      e_wr   = fwd ? (e_g ? wr1 : wr0) : 4'h0;
      push   = (e_rd || e_wr != 4'h0) && acc_dn;
      e_acc0 = push && !e_g;
      e_acc1 = push && e_g;
      pop    = ack_dn && !rst && (m_q.size() > 0);
      own    = pop ? m_q[0] : 1'b0;

      s_acc0 = acc0_o; s_acc1 = acc1_o; s_ack0 = ack0_o; s_ack1 = ack1_o;
      s_err0 = err0_o; s_err1 = err1_o; s_rd = dn_rd; s_addr = dn_addr;
      s_data0 = rdata0_o; s_tag0 = rtag0_o; s_tag1 = rtag1_o;

      check("accept0", acc0_o, e_acc0);
      check("accept1", acc1_o, e_acc1);
      check("dn_rd", dn_rd, e_rd);
      check("dn_wr", dn_wr, e_wr);
      check("dn_addr", dn_addr, e_g ? addr1 : addr0);
      check("dn_wdata", dn_wdata, e_g ? wdata1 : wdata0);
      check("dn_tag", dn_tag, e_g ? tag1 : tag0);
      check("dn_cach", dn_cach, e_g ? cach1 : cach0);
      check("ack0", ack0_o, pop && !own);
      check("ack1", ack1_o, pop && own);
      check("err0", err0_o, pop && !own && err_dn);
      check("err1", err1_o, pop && own && err_dn);
      if (pop && !own) begin
         check("rdata0", rdata0_o, rdata_dn);
         check("rtag0", rtag0_o, rtag_dn);
      end
      if (pop && own) begin
         check("rdata1", rdata1_o, rdata_dn);
         check("rtag1", rtag1_o, rtag_dn);
      end

      @(posedge clk);
      if (!rst) begin
         if (pop) begin
            void'(m_q.pop_front());
            void'(dn_q.pop_front());
         end
         if (push) begin
            m_q.push_back(e_g);
            dn_q.push_back(e_g ? tag1 : tag0);
            m_last = e_g;
            m_lock = 1'b0;
         end else if (e_g ? req1 : req0) begin
            m_lock       = 1'b1;
            m_lock_owner = e_g;
         end else begin
            m_lock = 1'b0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      m_reset();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      m_reset();
      pend0 = 0; pend1 = 0;
      @(posedge clk); #1;

      // ---- reset state
      do_reset();
      check("reset_acc0", s_acc0, 1'b0);
      check("reset_ack0", s_ack0, 1'b0);

      // ---- single port read with next-cycle ack
      rd0 = 1; addr0 = 32'h100; tag0 = 11'h005; acc_dn = 1;
      cycle();
      check("single_accept", s_acc0, 1'b1);
      rd0 = 0; acc_dn = 0; ack_dn = 1; rdata_dn = 32'hDEADBEEF; rtag_dn = 11'h005;
      cycle();
      check("single_ack0", s_ack0, 1'b1);
      check("single_data", s_data0, 32'hDEADBEEF);
      check("single_tag", s_tag0, 11'h005);
      check("single_ack1", s_ack1, 1'b0);
      ack_dn = 0;

      // ---- contention: grants alternate starting with port 0
      do_reset();
      rd0 = 1; rd1 = 1; tag0 = 11'h0A0; tag1 = 11'h1B1; acc_dn = 1;
      addr0 = 32'h1000; addr1 = 32'h2000;
      for (int k = 0; k < 6; k++) begin
         ack_dn  = (dn_q.size() > 0);
         rtag_dn = (dn_q.size() > 0) ? dn_q[0] : 11'h0;
         cycle();
         check("cont_acc0", s_acc0, (k % 2) == 0);
         check("cont_acc1", s_acc1, (k % 2) == 1);
         if (k > 0 && ((k - 1) % 2) == 0) check("cont_tag0", s_tag0, 11'h0A0);
         if (k > 0 && ((k - 1) % 2) == 1) check("cont_tag1", s_tag1, 11'h1B1);
      end

      // ---- lock: a stalled port 1 keeps the grant against port 0
      do_reset();
      addr0 = 32'hA0; addr1 = 32'hB0;
      rd1 = 1; acc_dn = 0;
      cycle();
      rd0 = 1;
      for (int k = 1; k < 3; k++) begin
         cycle();
         check("lock_addr", s_addr, 32'hB0);
         check("lock_acc0", s_acc0, 1'b0);
      end
      acc_dn = 1;
      cycle();
      check("lock_acc1", s_acc1, 1'b1);
      check("lock_acc0_c3", s_acc0, 1'b0);
      rd1 = 0;
      cycle();
      check("lock_acc0_c4", s_acc0, 1'b1);

      // ---- full: four outstanding blocks the fifth until an ack drains one
      do_reset();
      rd0 = 1; acc_dn = 1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("fill_acc", s_acc0, 1'b1);
      end
      cycle();
      check("full_rd", s_rd, 1'b0);
      check("full_acc", s_acc0, 1'b0);
      ack_dn = 1; rtag_dn = dn_q[0];
      cycle();
      check("full_pop_ack", s_ack0, 1'b1);
      check("full_pop_acc", s_acc0, 1'b0);
      ack_dn = 0;
      cycle();
      check("after_pop_acc", s_acc0, 1'b1);

      // ---- ordering: owners 0,1,0 with an error on the second response
      do_reset();
      acc_dn = 1;
      rd0 = 1; tag0 = 11'h001; cycle();
      rd0 = 0; rd1 = 1; tag1 = 11'h002; cycle();
      rd1 = 0; rd0 = 1; tag0 = 11'h003; cycle();
      rd0 = 0; acc_dn = 0; ack_dn = 1;
      rtag_dn = 11'h001; cycle();
      check("ord1_ack0", s_ack0, 1'b1);
      check("ord1_tag", s_tag0, 11'h001);
      rtag_dn = 11'h002; err_dn = 1; cycle();
      check("ord2_ack1", s_ack1, 1'b1);
      check("ord2_err1", s_err1, 1'b1);
      check("ord2_err0", s_err0, 1'b0);
      rtag_dn = 11'h003; err_dn = 0; cycle();
      check("ord3_ack0", s_ack0, 1'b1);
      check("ord3_tag", s_tag0, 11'h003);
      ack_dn = 0;

      // ---- asynchronous reset with two outstanding, then a spurious ack
      do_reset();
      rd0 = 1; acc_dn = 1;
      cycle(); cycle();
      ack_dn = 1; rtag_dn = 11'h011;
      #1;
      check("pre_rst_ack0", ack0_o, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_ack0", ack0_o, 1'b0);
      check("rst_acc0", acc0_o, 1'b0);
      check("rst_rd", dn_rd, 1'b0);
      m_reset();
      cycle();
      rst = 1'b0; rd0 = 0;
      cycle();
      check("spur_ack0", s_ack0, 1'b0);
      check("spur_ack1", s_ack1, 1'b0);

      // ---- random traffic against the reference model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (i == 250) begin
            do_reset();
            pend0 = 0; pend1 = 0;
         end
         if (!pend0 && $urandom_range(0, 2) == 0) begin
            pend0 = 1;
            if ($urandom_range(0, 1) == 1) begin rd0 = 1; wr0 = 4'h0; end
            else begin rd0 = 0; wr0 = 4'($urandom_range(1, 15)); end
            addr0 = $urandom; wdata0 = $urandom; tag0 = 11'($urandom); cach0 = 1'($urandom);
         end
         if (!pend1 && $urandom_range(0, 2) == 0) begin
            pend1 = 1;
            if ($urandom_range(0, 1) == 1) begin rd1 = 1; wr1 = 4'h0; end
            else begin rd1 = 0; wr1 = 4'($urandom_range(1, 15)); end
            addr1 = $urandom; wdata1 = $urandom; tag1 = 11'($urandom); cach1 = 1'($urandom);
         end
         acc_dn   = ($urandom_range(0, 3) != 0);
         ack_dn   = ($urandom_range(0, 2) == 0);
         err_dn   = ($urandom_range(0, 7) == 0);
         rdata_dn = $urandom;
         rtag_dn  = (dn_q.size() > 0) ? dn_q[0] : 11'($urandom);
         cycle();
         if (e_acc0) begin pend0 = 0; rd0 = 0; wr0 = 4'h0; end
         if (e_acc1) begin pend1 = 0; rd1 = 0; wr1 = 4'h0; end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
